serin: RTL and testbench



---
 rtl/serin.sv | 198 +++++++++++++++++++
 tb/tb_serin.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/serin.sv
// Octal 8N1 serial receiver bank on the peripheral bus daisy chain.
// Each port oversamples its line on the u1clk tick and holds the last character received.
module serin #(
   parameter int NPORT    = 8,
   parameter int LOGNPORT = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             rdwr,
   input  logic             strobe,
   input  logic [3:0]       our_addr,
   input  logic [11:0]      addr,
   input  logic             busy_in,
   output logic             busy_out,
   input  logic             addr_match_in,
   output logic             addr_match_out,
   input  logic [7:0]       datin,
   output logic [7:0]       datout,
   input  logic             u1clk,
   input  logic [NPORT-1:0] rxd
);

   localparam logic [LOGNPORT:0] R_CFG  = (LOGNPORT+1)'(NPORT);
   localparam logic [LOGNPORT:0] R_RDY  = (LOGNPORT+1)'(NPORT + 1);
   localparam logic [LOGNPORT:0] R_OVR  = (LOGNPORT+1)'(NPORT + 2);
   localparam logic [LOGNPORT:0] R_FERR = (LOGNPORT+1)'(NPORT + 3);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_WAITHI
   } rx_state_t;

   logic [3:0]         bauddiv_reg;
   logic [NPORT-1:0]   ready_reg;
   logic [NPORT-1:0]   ovr_reg;
   logic [NPORT-1:0]   ferr_reg;
   logic [NPORT-1:0]   deliver;
   logic [NPORT-1:0]   ferr_set;
   logic [NPORT-1:0]   clr_ready;
   logic [NPORT*8-1:0] data_all;

   logic [LOGNPORT:0] r;
   logic              myaddr;
   logic              reg_hit;
   logic              rd_en;
   logic              rd_data;
   logic              rd_ovr;
   logic              rd_ferr;
   logic              wr_cfg;
   logic [8:0]        bd_p1;
   logic [8:0]        per_m1;
   logic [8:0]        half_m1;

   assign r       = addr[LOGNPORT:0];
   assign myaddr  = (addr[11:8] == our_addr) && (addr[7:LOGNPORT+1] == '0);
   assign reg_hit = (r <= R_FERR);
   assign rd_en   = myaddr && strobe && rdwr;
   assign rd_data = rd_en && (r < R_CFG);
   assign rd_ovr  = rd_en && (r == R_OVR);
   assign rd_ferr = rd_en && (r == R_FERR);
   assign wr_cfg  = myaddr && strobe && !rdwr && (r == R_CFG);

   assign clr_ready = {NPORT{rd_data}} & (NPORT'(1) << r[LOGNPORT-1:0]);

   // Bit and half-bit periods in u1clk ticks; 26 ticks per bit at 38400 baud.
   assign bd_p1   = {5'd0, bauddiv_reg} + 9'd1;
   assign per_m1  = (bd_p1 * 9'd26) - 9'd1;
   assign half_m1 = (bd_p1 * 9'd13) - 9'd1;

   assign busy_out = busy_in;

   assign addr_match_out = addr_match_in
                         | (myaddr && reg_hit && (r >= R_CFG))
                         | (myaddr && (r < R_CFG) && ready_reg[r[LOGNPORT-1:0]]);

   always_comb begin
      datout = datin;
      if (myaddr && reg_hit) begin
         datout = 8'h00;
         if (strobe && rdwr) begin
            if (r < R_CFG) begin
               datout = data_all[{r[LOGNPORT-1:0], 3'b000} +: 8];
            end else begin
               case (r)
                  R_CFG:   datout = {4'h0, bauddiv_reg};
                  R_RDY:   datout = 8'(ready_reg);
                  R_OVR:   datout = 8'(ovr_reg);
                  R_FERR:  datout = 8'(ferr_reg);
                  default: datout = 8'h00;
               endcase
            end
         end
      end
   end

   // Setting a flag beats a same-cycle clearing read, so no event is lost.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bauddiv_reg <= 4'h0;
         ready_reg   <= '0;
         ovr_reg     <= '0;
         ferr_reg    <= '0;
      end else begin
         if (wr_cfg) bauddiv_reg <= datin[3:0];
         ready_reg <= (ready_reg & ~clr_ready) | deliver;
         ovr_reg   <= (rd_ovr ? '0 : ovr_reg) | (deliver & ready_reg & ~clr_ready);
         ferr_reg  <= (rd_ferr ? '0 : ferr_reg) | ferr_set;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NPORT; gi++) begin : g_port
         logic       sync1_reg;
         logic       rxs_reg;
         rx_state_t  state_reg;
         logic [8:0] cnt_reg;
         logic [2:0] bitcnt_reg;
         logic [7:0] shreg_reg;
         logic [7:0] data_reg;
         logic       stop_exp;

         assign stop_exp      = (state_reg == ST_STOP) && u1clk && (cnt_reg == 9'd0);
         assign deliver[gi]   = stop_exp && rxs_reg;
         assign ferr_set[gi]  = stop_exp && !rxs_reg;
         assign data_all[gi*8 +: 8] = data_reg;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               sync1_reg  <= 1'b1;
               rxs_reg    <= 1'b1;
               state_reg  <= ST_IDLE;
               cnt_reg    <= 9'd0;
               bitcnt_reg <= 3'd0;
               shreg_reg  <= 8'h00;
               data_reg   <= 8'h00;
            end else begin
               sync1_reg <= rxd[gi];
               rxs_reg   <= sync1_reg;
               case (state_reg)
                  ST_IDLE: begin
                     if (!rxs_reg) begin
                        state_reg <= ST_START;
                        cnt_reg   <= half_m1;
                     end
                  end
                  ST_START: begin
                     if (u1clk) begin
                        if (cnt_reg != 9'd0) begin
                           cnt_reg <= cnt_reg - 9'd1;
                        end else if (!rxs_reg) begin
                           state_reg  <= ST_DATA;
                           cnt_reg    <= per_m1;
                           bitcnt_reg <= 3'd0;
                        end else begin
                           state_reg <= ST_IDLE;
                        end
                     end
                  end
                  ST_DATA: begin
                     if (u1clk) begin
                        if (cnt_reg != 9'd0) begin
                           cnt_reg <= cnt_reg - 9'd1;
                        end else begin
                           shreg_reg  <= {rxs_reg, shreg_reg[7:1]};
                           bitcnt_reg <= bitcnt_reg + 3'd1;
                           cnt_reg    <= per_m1;
                           if (bitcnt_reg == 3'd7) state_reg <= ST_STOP;
                        end
                     end
                  end
                  ST_STOP: begin
                     if (u1clk) begin
                        if (cnt_reg != 9'd0) begin
                           cnt_reg <= cnt_reg - 9'd1;
                        end else if (rxs_reg) begin
                           data_reg  <= shreg_reg;
                           state_reg <= ST_IDLE;
                        end else begin
                           state_reg <= ST_WAITHI;
                        end
                     end
                  end
                  ST_WAITHI: begin
                     // A held break must return high before a new start bit counts.
                     if (rxs_reg) state_reg <= ST_IDLE;
                  end
                  default: state_reg <= ST_IDLE;
               endcase
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_serin.sv
// Directed bench for serin: serial characters on the rxd lines, register reads over the bus.
module tb_serin;
   localparam logic [3:0] OUR = 4'h3;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        rdwr = 1'b0;
   logic        strobe = 1'b0;
   logic [3:0]  our_addr = OUR;
   logic [11:0] addr = 12'h000;
   logic        busy_in = 1'b0;
   logic        busy_out;
   logic        addr_match_in = 1'b0;
   logic        addr_match_out;
   logic [7:0]  datin = 8'h00;
   logic [7:0]  datout;
   logic        u1clk = 1'b0;
   logic [7:0]  rxd = 8'hFF;

   int vectors = 0;
   int errors  = 0;

   serin #(.NPORT(8), .LOGNPORT(3)) dut (
      .clk(clk), .reset_n(reset_n), .rdwr(rdwr), .strobe(strobe),
      .our_addr(our_addr), .addr(addr), .busy_in(busy_in), .busy_out(busy_out),
      .addr_match_in(addr_match_in), .addr_match_out(addr_match_out),
      .datin(datin), .datout(datout), .u1clk(u1clk), .rxd(rxd)
   );

   always #5 clk = ~clk;

   // One u1clk tick every 4 clk keeps the run short.
   initial begin
      forever begin
         repeat (3) @(negedge clk);
         u1clk = 1'b1;
         @(negedge clk);
         u1clk = 1'b0;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required normal completion");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      vectors++;
      assert (got === exp) else begin
         errors++;
         $display("FAIL %s: observed %02h expected %02h", tag, got, exp);
         $error("%s miscompare", tag);
      end
   endtask

   task automatic ticks(input int n);
      repeat (n) @(posedge u1clk);
   endtask

   task automatic rd(input logic [3:0] r, output logic [7:0] d, output logic m);
      @(negedge clk);
      addr = {OUR, 4'h0, r};
      rdwr = 1'b1;
      strobe = 1'b1;
      #1;
      d = datout;
      m = addr_match_out;
      @(negedge clk);
      strobe = 1'b0;
      addr = 12'h000;
   endtask

   task automatic rdchk(input string tag, input logic [3:0] r, input logic [7:0] exp);
      logic [7:0] d;
      logic m;
      rd(r, d, m);
      chk(tag, d, exp);
      chk({tag, "_claim"}, {7'd0, m}, 8'h01);
      $display("read r=%0d data=%02h claim=%0d (%s)", r, d, m, tag);
   endtask

   task automatic wr(input logic [3:0] r, input logic [7:0] d);
      @(negedge clk);
      addr = {OUR, 4'h0, r};
      rdwr = 1'b0;
      datin = d;
      strobe = 1'b1;
      @(negedge clk);
      strobe = 1'b0;
      addr = 12'h000;
      datin = 8'h00;
      $display("write r=%0d data=%02h", r, d);
   endtask

   task automatic send(input logic [7:0] mask, input logic [63:0] bytes,
                       input logic stop_val, input int bt);
      for (int b = 0; b < 10; b++) begin
         for (int p = 0; p < 8; p++) begin
            if (mask[p]) begin
               if (b == 0)      rxd[p] = 1'b0;
               else if (b == 9) rxd[p] = stop_val;
               else             rxd[p] = bytes[p*8 + b - 1];
            end
         end
         ticks(bt);
      end
   endtask

   task automatic send1(input int p, input logic [7:0] byte_v, input logic stop_val, input int bt);
      send(8'(1 << p), {8{byte_v}}, stop_val, bt);
      $display("sent %02h on rxd[%0d] stop=%0d", byte_v, p, stop_val);
   endtask

   initial begin
      logic [7:0] d;
      logic m;
      logic [63:0] multi;

      repeat (5) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // reset state
      rdchk("rst_ready", 4'd9, 8'h00);
      rdchk("rst_cfg", 4'd8, 8'h00);
      rdchk("rst_ovr", 4'd10, 8'h00);
      rdchk("rst_ferr", 4'd11, 8'h00);

      // pass-throughs when not addressed
      @(negedge clk);
      addr = 12'h5A9; datin = 8'hA5; busy_in = 1'b1; addr_match_in = 1'b1;
      #1;
      chk("pass_dat", datout, 8'hA5);
      chk("pass_busy", {7'd0, busy_out}, 8'h01);
      chk("pass_match", {7'd0, addr_match_out}, 8'h01);
      @(negedge clk);
      addr = 12'h000; datin = 8'h00; busy_in = 1'b0; addr_match_in = 1'b0;

      // 0x55 on port 2
      send1(2, 8'h55, 1'b1, 26);
      rdchk("t1_ready", 4'd9, 8'h04);
      rdchk("t1_data", 4'd2, 8'h55);
      rdchk("t1_ready_clr", 4'd9, 8'h00);

      // overrun on port 0
      send1(0, 8'h41, 1'b1, 26);
      send1(0, 8'h42, 1'b1, 26);
      rdchk("t2_data", 4'd0, 8'h42);
      rdchk("t2_ovr", 4'd10, 8'h01);
      rdchk("t2_ovr_clr", 4'd10, 8'h00);

      // 5 us glitch on port 5
      rxd[5] = 1'b0;
      ticks(5);
      rxd[5] = 1'b1;
      ticks(50);
      rdchk("t3_ready", 4'd9, 8'h00);
      rdchk("t3_ferr", 4'd11, 8'h00);
      send1(5, 8'hA3, 1'b1, 26);
      rdchk("t3_data", 4'd5, 8'hA3);

      // framing error then break on port 7
      send1(7, 8'hFF, 1'b0, 26);
      rdchk("t4_ferr", 4'd11, 8'h80);
      rdchk("t4_ready", 4'd9, 8'h00);
      ticks(1000);
      rdchk("t4_ferr_break", 4'd11, 8'h00);
      rdchk("t4_ready_break", 4'd9, 8'h00);
      rxd[7] = 1'b1;
      ticks(5);
      send1(7, 8'h12, 1'b1, 26);
      rdchk("t4_data", 4'd7, 8'h12);
      rdchk("t4_ferr_after", 4'd11, 8'h00);

      // all ports at bauddiv 1
      wr(4'd8, 8'h01);
      rdchk("t5_cfg", 4'd8, 8'h01);
      multi = 64'h3736_3534_3332_3130;
      send(8'hFF, multi, 1'b1, 52);
      rdchk("t5_ready", 4'd9, 8'hFF);
      for (int i = 0; i < 8; i++) rdchk($sformatf("t5_data%0d", i), 4'(i), 8'(8'h30 + i));
      rdchk("t5_ready_clr", 4'd9, 8'h00);
      rdchk("t5_ovr", 4'd10, 8'h00);

      // reset during bit 4 of a character on port 1
      wr(4'd8, 8'h00);
      rxd[1] = 1'b0;
      ticks(26);
      for (int b = 0; b < 4; b++) begin
         rxd[1] = b[0];
         ticks(26);
      end
      rxd[1] = 1'b1;
      ticks(10);
      @(negedge clk);
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      $display("reset pulsed mid-character on rxd[1]");
      ticks(16 + 3 * 26 + 26);
      rdchk("t6_ready", 4'd9, 8'h00);
      rdchk("t6_ovr", 4'd10, 8'h00);
      rdchk("t6_ferr", 4'd11, 8'h00);
      send1(1, 8'h7E, 1'b1, 26);
      rdchk("t6_data", 4'd1, 8'h7E);

      // empty-port read is not claimed
      addr_match_in = 1'b0;
      rd(4'd1, d, m);
      chk("t6_empty_claim0", {7'd0, m}, 8'h00);
      addr_match_in = 1'b1;
      rd(4'd1, d, m);
      chk("t6_empty_claim1", {7'd0, m}, 8'h01);
      addr_match_in = 1'b0;
      $display("empty port read claim checks done");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
